// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer -- memory-mapped 32-bit timer peripheral for the data-memory bus.
//
// Sits beside the data RAM on the mem-stage port and uses the same protocol,
// so the mem-stage read mux treats both identically.
//
// Features:
//   - free-running 32-bit COUNT, advanced once per tick
//   - optional 8-bit prescaler (built only when TIMER_PRESC_EN is defined)
//   - CMP register with a sticky PEND flag and optional auto-clear of COUNT
//   - level interrupt irq_o = PEND & IRQ_EN
//
// Build option:
//   TIMER_PRESC_EN  defined   : prescale counter built, CTRL[15:8] = PRESC
//                   undefined : one tick per cycle while EN=1,
//                               CTRL[15:8] ignores writes and reads 0
//
// Register map (addr[3:2]):
//   0 CTRL   : [0] EN, [1] IRQ_EN, [2] AUTO, [15:8] PRESC, others read 0
//   1 COUNT  : 32-bit read/write
//   2 CMP    : 32-bit read/write
//   3 STATUS : [0] PEND, write 1 to clear, others read 0
//
// Bus protocol: there is no valid/ready handshake. A transfer is accepted
// unconditionally on every clock edge where cs=1; we selects write (1) or
// read (0). A write updates only the bytes whose wem bit is set (wem=0 is a
// no-op). A read loads data_o at that edge, and data_o holds its value at
// all other times (1-cycle read latency, like the RAM).
//
// Ports:
//   clk      in   1  core clock
//   rst      in   1  asynchronous active-high reset
//   cs       in   1  chip select from the address decoder
//   we       in   1  1 = write, 0 = read (qualified by cs)
//   wem      in   4  byte write mask, bit n enables data_in[8n+7:8n]
//   addr     in  32  byte address, only addr[3:2] decoded
//   data_in  in  32  write data
//   data_o   out 32  registered read data
//   irq_o    out  1  level interrupt
// ---------------------------------------------------------------------------
module timer #(
   parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        we,
   input  logic [3:0]  wem,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_o,
   output logic        irq_o
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_COUNT  = 2'd1;
   localparam logic [1:0] A_CMP    = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   // Replace the bytes of old_v selected by mask with those of new_v.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   // Bus decode
   logic [1:0] reg_sel;
   logic       bus_wr;
   logic       bus_rd;
   logic       wr_ctrl;
   logic       wr_count;
   logic       wr_cmp;
   logic       wr_status;

   assign reg_sel   = addr[3:2];
   assign bus_wr    = cs & we & (|wem);
   assign bus_rd    = cs & ~we;
   assign wr_ctrl   = bus_wr & (reg_sel == A_CTRL);
   assign wr_count  = bus_wr & (reg_sel == A_COUNT);
   assign wr_cmp    = bus_wr & (reg_sel == A_CMP);
   assign wr_status = bus_wr & (reg_sel == A_STATUS);

   // Only addr[3:2] matters; the rest is intentionally ignored.
   logic unused_addr;
   assign unused_addr = ^{addr[31:4], addr[1:0]};

   // State registers
   logic        en_q,     en_d;
   logic        irq_en_q, irq_en_d;
   logic        auto_q,   auto_d;
   logic [31:0] count_q,  count_d;
   logic [31:0] cmp_q,    cmp_d;
   logic        pend_q,   pend_d;
   logic [31:0] data_q,   data_d;

   logic        tick;
   logic [7:0]  presc_rd;

`ifdef TIMER_PRESC_EN
   logic [7:0] presc_q, presc_d;
   logic [7:0] pcnt_q,  pcnt_d;

   // A tick fires on the cycle pcnt reaches PRESC, giving a period of
   // PRESC+1 cycles.
   assign tick     = en_q & (pcnt_q == presc_q);
   assign presc_rd = presc_q;

   always_comb begin
      presc_d = presc_q;
      if (wr_ctrl && wem[1]) presc_d = data_in[15:8];

      // Any CTRL write restarts the prescale phase so a new PRESC/EN takes
      // effect from a known point.
      if (wr_ctrl || !en_q || tick) pcnt_d = 8'd0;
      else                          pcnt_d = pcnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= 8'd0;
         pcnt_q  <= 8'd0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end
`else
   assign tick     = en_q;
   assign presc_rd = 8'h00;
`endif

   // CTRL low bits
   always_comb begin
      en_d     = en_q;
      irq_en_d = irq_en_q;
      auto_d   = auto_q;
      if (wr_ctrl && wem[0]) begin
         en_d     = data_in[0];
         irq_en_d = data_in[1];
         auto_d   = data_in[2];
      end
   end

   // COUNT / match / PEND. The match uses pre-write COUNT and CMP, and a
   // bus write to COUNT replaces the tick update entirely.
   logic match_hit;
   logic pend_clr;

   assign match_hit = tick & (count_q == cmp_q);
   assign pend_clr  = wr_status & wem[0] & data_in[0];

   always_comb begin
      count_d = count_q;
      if (tick) begin
         if (match_hit && auto_q) count_d = 32'd0;
         else                     count_d = count_q + 32'd1;
      end
      if (wr_count) count_d = merge_bytes(count_q, data_in, wem);
   end

   always_comb begin
      cmp_d = cmp_q;
      if (wr_cmp) cmp_d = merge_bytes(cmp_q, data_in, wem);
   end

   // Set wins over a same-cycle write-1-to-clear.
   always_comb begin
      pend_d = pend_q & ~pend_clr;
      if (match_hit) pend_d = 1'b1;
   end

   // Read path: sample the addressed register as it was before this edge.
   logic [31:0] rd_val;

   always_comb begin
      rd_val = 32'd0;
      unique case (reg_sel)
         A_CTRL:   rd_val = {16'h0000, presc_rd, 5'b00000, auto_q, irq_en_q, en_q};
         A_COUNT:  rd_val = count_q;
         A_CMP:    rd_val = cmp_q;
         A_STATUS: rd_val = {31'd0, pend_q};
         default:  rd_val = 32'd0;
      endcase
   end

   always_comb begin
      data_d = data_q;
      if (bus_rd) data_d = rd_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         auto_q   <= 1'b0;
         count_q  <= 32'd0;
         cmp_q    <= RESET_CMP;
         pend_q   <= 1'b0;
         data_q   <= 32'd0;
      end else begin
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         auto_q   <= auto_d;
         count_q  <= count_d;
         cmp_q    <= cmp_d;
         pend_q   <= pend_d;
         data_q   <= data_d;
      end
   end

   assign data_o = data_q;
   assign irq_o  = pend_q & irq_en_q;

endmodule

// File: tb/tb_timer.sv
// ---------------------------------------------------------------------------
// tb_timer -- self-checking bench for timer.
//
// A behavioural model tracks the register file from the bus traffic and the
// tick rule (ticks every PRESC+1 enabled cycles since the last CTRL write);
// a compare process checks data_o and irq_o against it every cycle. Directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_timer;

   logic        clk;
   logic        rst;
   logic        cs;
   logic        we;
   logic [3:0]  wem;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_o;
   logic        irq_o;

   int n_cmp = 0;
   int n_mis = 0;
   bit chk_on = 0;

   timer dut (
      .clk     (clk),
      .rst     (rst),
      .cs      (cs),
      .we      (we),
      .wem     (wem),
      .addr    (addr),
      .data_in (data_in),
      .data_o  (data_o),
      .irq_o   (irq_o)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model ----------------
   bit          m_en = 0, m_irq_en = 0, m_auto = 0, m_pend = 0;
   logic [7:0]  m_presc = 8'h00;
   logic [31:0] m_count = 32'd0;
   logic [31:0] m_cmp   = 32'hFFFF_FFFF;
   logic [31:0] m_rd    = 32'd0;
   int          m_since = 0;   // enabled cycles since last CTRL write

   function automatic logic [31:0] put_bytes(input logic [31:0] o,
                                             input logic [31:0] n,
                                             input logic [3:0]  m);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic model_step();
      bit          wr, tick, hit;
      logic [1:0]  a;
      logic [31:0] old_count;
      if (rst) begin
         m_en = 0; m_irq_en = 0; m_auto = 0; m_pend = 0;
         m_presc = 8'h00; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
         m_rd = 32'd0; m_since = 0;
         return;
      end
      a  = addr[3:2];
      wr = cs && we && (wem != 4'b0000);
      if (cs && !we) begin
         case (a)
            2'd0: m_rd = {16'h0000, m_presc, 5'b00000, m_auto, m_irq_en, m_en};
            2'd1: m_rd = m_count;
            2'd2: m_rd = m_cmp;
            default: m_rd = {31'd0, m_pend};
         endcase
      end
      tick = m_en && ((m_since % (int'(m_presc) + 1)) == int'(m_presc));
      hit  = tick && (m_count == m_cmp);
      old_count = m_count;
      if (tick) m_count = (hit && m_auto) ? 32'd0 : m_count + 32'd1;
      if (wr && a == 2'd1) m_count = put_bytes(old_count, data_in, wem);
      if (wr && a == 2'd2) m_cmp = put_bytes(m_cmp, data_in, wem);
      if (wr && a == 2'd3 && wem[0] && data_in[0]) m_pend = 0;
      if (hit) m_pend = 1;
      if (m_en) m_since++;
      if (wr && a == 2'd0) begin
         m_since = 0;
         if (wem[0]) begin
            m_en     = data_in[0];
            m_irq_en = data_in[1];
            m_auto   = data_in[2];
         end
`ifdef TIMER_PRESC_EN
         if (wem[1]) m_presc = data_in[15:8];
`endif
      end
      if (!m_en) m_since = 0;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            check("model data_o", data_o, m_rd);
            check("model irq_o", {31'd0, irq_o}, {31'd0, m_pend & m_irq_en});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Each task starts just after a falling edge and returns just after one.
   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
      cs = 1'b1; we = 1'b1; wem = m; addr = {28'd0, a, 2'b00}; data_in = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; wem = 4'b0000; data_in = 32'd0;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
      cs = 1'b1; we = 1'b0; wem = 4'b0000; addr = {28'd0, a, 2'b00};
      @(negedge clk);
      cs = 1'b0;
      check(name, data_o, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] ctrl_exp;
      rst = 1'b1; cs = 1'b0; we = 1'b0; wem = 4'b0000; addr = 32'd0; data_in = 32'd0;
      idle(2);
      rst = 1'b0;
      chk_on = 1;

      // Reset values
      rd_chk(2'd0, 32'h0000_0000, "reset CTRL");
      rd_chk(2'd1, 32'h0000_0000, "reset COUNT");
      rd_chk(2'd2, 32'hFFFF_FFFF, "reset CMP");
      rd_chk(2'd3, 32'h0000_0000, "reset STATUS");

      // CTRL field mask: EN/IRQ_EN/AUTO left 0, all other bits written 1
`ifdef TIMER_PRESC_EN
      ctrl_exp = 32'h0000_FF00;
`else
      ctrl_exp = 32'h0000_0000;
`endif
      wr(2'd0, 32'hFFFF_FFF8, 4'hF);
      rd_chk(2'd0, ctrl_exp, "CTRL read mask");
      wr(2'd0, 32'h0, 4'hF);

      // Free run, PRESC=0
      wr(2'd2, 32'h0000_1000, 4'hF);
      wr(2'd0, 32'h1, 4'h1);
      idle(10);
      rd_chk(2'd1, 32'd10, "free run COUNT");
      wr(2'd1, 32'hFFFF_FFFE, 4'hF);
      idle(2);
      rd_chk(2'd1, 32'd0, "wrap COUNT");
      rd_chk(2'd3, 32'd0, "wrap no PEND");
      wr(2'd0, 32'h0, 4'hF);

`ifdef TIMER_PRESC_EN
      // Prescale by 4
      wr(2'd1, 32'h0, 4'hF);
      wr(2'd0, 32'h0000_0301, 4'hF);
      idle(40);
      rd_chk(2'd1, 32'd10, "prescale COUNT");
      wr(2'd0, 32'h0, 4'hF);
`endif

      // Compare + IRQ with AUTO
      wr(2'd1, 32'h0, 4'hF);
      wr(2'd2, 32'd5, 4'hF);
      wr(2'd0, 32'h7, 4'h1);
      idle(5);
      check("irq before match", {31'd0, irq_o}, 32'd0);
      idle(1);
      check("irq on match", {31'd0, irq_o}, 32'd1);
      rd_chk(2'd1, 32'd0, "AUTO clear COUNT");
      wr(2'd3, 32'h1, 4'h1);
      check("irq after W1C", {31'd0, irq_o}, 32'd0);
      wr(2'd0, 32'h0, 4'hF);

      // Collision: partial COUNT write on a tick cycle
      wr(2'd2, 32'h0000_9000, 4'hF);
      wr(2'd1, 32'h1234_5678, 4'hF);
      wr(2'd0, 32'h1, 4'h1);
      wr(2'd1, 32'h0000_0100, 4'b0001);
      wr(2'd0, 32'h0, 4'hF);
      rd_chk(2'd1, 32'h1234_5601, "COUNT write beats tick");

      // Collision: W1C STATUS on a matching tick
      wr(2'd1, 32'h0, 4'hF);
      wr(2'd2, 32'd2, 4'hF);
      wr(2'd0, 32'h1, 4'h1);
      idle(2);
      wr(2'd3, 32'h1, 4'h1);
      wr(2'd0, 32'h0, 4'hF);
      rd_chk(2'd3, 32'd1, "PEND set beats W1C");

      // Byte masks on CMP
      wr(2'd2, 32'h0, 4'hF);
      wr(2'd2, 32'hAABB_CCDD, 4'b1010);
      rd_chk(2'd2, 32'hAA00_CC00, "CMP byte mask");
      wr(2'd2, 32'h1234_5678, 4'b0000);
      rd_chk(2'd2, 32'hAA00_CC00, "CMP wem=0");

      // Reset mid-count with PEND=1 and IRQ enabled
      wr(2'd0, 32'h3, 4'h1);
      idle(3);
      check("irq before reset", {31'd0, irq_o}, 32'd1);
      rd_chk(2'd2, 32'hAA00_CC00, "CMP before reset");
      #2 rst = 1'b1;
      #1;
      check("reset data_o", data_o, 32'd0);
      check("reset irq_o", {31'd0, irq_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk(2'd0, 32'h0000_0000, "post-reset CTRL");
      rd_chk(2'd1, 32'h0000_0000, "post-reset COUNT");
      rd_chk(2'd2, 32'hFFFF_FFFF, "post-reset CMP");
      rd_chk(2'd3, 32'h0000_0000, "post-reset STATUS");

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
